axil_demux_1xn: RTL and testbench

//  Parametrised AXI4-Lite 1-to-N address demultiplexer with a programmable address map.

---
 rtl/axil_demux_1xn.sv | 276 +++++++++++++++++++++++++++
 tb/tb_axil_demux_1xn.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/axil_demux_1xn.sv
// AXI4-Lite 1-to-N address demultiplexer with BASE/MASK decode and a local DECERR responder.
// Read and write paths are independent FSMs, each allowing one outstanding transaction.
module axil_demux_1xn #(
   parameter int N_PORTS      = 4,
   parameter int ADDR_WIDTH   = 32,
   parameter int M_ADDR_WIDTH = 24,
   parameter int DATA_WIDTH   = 32,
   parameter int STRB_WIDTH   = DATA_WIDTH/8,
   parameter logic [N_PORTS*ADDR_WIDTH-1:0] BASE_ADDR = {N_PORTS{32'h0}},
   parameter logic [N_PORTS*ADDR_WIDTH-1:0] ADDR_MASK = {N_PORTS{32'hF000_0000}}
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [ADDR_WIDTH-1:0]           s_awaddr,
   input  logic [2:0]                      s_awprot,
   input  logic                            s_awvalid,
   output logic                            s_awready,
   input  logic [DATA_WIDTH-1:0]           s_wdata,
   input  logic [STRB_WIDTH-1:0]           s_wstrb,
   input  logic                            s_wvalid,
   output logic                            s_wready,
   output logic [1:0]                      s_bresp,
   output logic                            s_bvalid,
   input  logic                            s_bready,
   input  logic [ADDR_WIDTH-1:0]           s_araddr,
   input  logic [2:0]                      s_arprot,
   input  logic                            s_arvalid,
   output logic                            s_arready,
   output logic [DATA_WIDTH-1:0]           s_rdata,
   output logic [1:0]                      s_rresp,
   output logic                            s_rvalid,
   input  logic                            s_rready,
   output logic [N_PORTS*M_ADDR_WIDTH-1:0] m_awaddr,
   output logic [N_PORTS*3-1:0]            m_awprot,
   output logic [N_PORTS-1:0]              m_awvalid,
   input  logic [N_PORTS-1:0]              m_awready,
   output logic [N_PORTS*DATA_WIDTH-1:0]   m_wdata,
   output logic [N_PORTS*STRB_WIDTH-1:0]   m_wstrb,
   output logic [N_PORTS-1:0]              m_wvalid,
   input  logic [N_PORTS-1:0]              m_wready,
   input  logic [N_PORTS*2-1:0]            m_bresp,
   input  logic [N_PORTS-1:0]              m_bvalid,
   output logic [N_PORTS-1:0]              m_bready,
   output logic [N_PORTS*M_ADDR_WIDTH-1:0] m_araddr,
   output logic [N_PORTS*3-1:0]            m_arprot,
   output logic [N_PORTS-1:0]              m_arvalid,
   input  logic [N_PORTS-1:0]              m_arready,
   input  logic [N_PORTS*DATA_WIDTH-1:0]   m_rdata,
   input  logic [N_PORTS*2-1:0]            m_rresp,
   input  logic [N_PORTS-1:0]              m_rvalid,
   output logic [N_PORTS-1:0]              m_rready,
   output logic                            dec_err
);

   localparam int SEL_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT_B, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT_R, R_RESP} r_state_t;

   // Returns {hit, sel}; scanning downward lets the lowest matching index win.
   function automatic logic [SEL_W:0] decode(input logic [ADDR_WIDTH-1:0] addr);
      logic [SEL_W:0] r;
      r = '0;
      for (int i = N_PORTS-1; i >= 0; i--) begin
         if ((addr & ADDR_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH])
            r = {1'b1, SEL_W'(i)};
      end
      return r;
   endfunction

   w_state_t                w_state_q, w_state_d;
   logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic                    aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [2:0]              awprot_q, awprot_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
   logic [SEL_W-1:0]        w_sel_q, w_sel_d;
   logic [1:0]              bresp_q, bresp_d;

   r_state_t                r_state_q, r_state_d;
   logic [M_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [2:0]              arprot_q, arprot_d;
   logic [SEL_W-1:0]        r_sel_q, r_sel_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;

   logic                    dec_err_q, dec_err_d;
   logic                    w_miss, r_miss, aw_fire, w_fire;
   logic [ADDR_WIDTH-1:0]   w_addr_eff;
   logic [SEL_W:0]          w_dec, r_dec;

   always_comb begin
      w_state_d  = w_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      aw_pend_d  = aw_pend_q;
      w_pend_d   = w_pend_q;
      awaddr_d   = awaddr_q;
      awprot_d   = awprot_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      w_sel_d    = w_sel_q;
      bresp_d    = bresp_q;
      s_awready  = 1'b0;
      s_wready   = 1'b0;
      s_bvalid   = 1'b0;
      m_awvalid  = '0;
      m_wvalid   = '0;
      m_bready   = '0;
      w_miss     = 1'b0;
      aw_fire    = 1'b0;
      w_fire     = 1'b0;
      w_addr_eff = awaddr_q;
      w_dec      = '0;
      case (w_state_q)
         W_IDLE: begin
            s_awready = !aw_held_q;
            s_wready  = !w_held_q;
            aw_fire   = s_awvalid && !aw_held_q;
            w_fire    = s_wvalid && !w_held_q;
            if (aw_fire) begin
               awaddr_d   = s_awaddr;
               awprot_d   = s_awprot;
               aw_held_d  = 1'b1;
               w_addr_eff = s_awaddr;
            end
            if (w_fire) begin
               wdata_d  = s_wdata;
               wstrb_d  = s_wstrb;
               w_held_d = 1'b1;
            end
            if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
               w_dec     = decode(w_addr_eff);
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               if (w_dec[SEL_W]) begin
                  w_state_d = W_ISSUE;
                  w_sel_d   = w_dec[SEL_W-1:0];
                  aw_pend_d = 1'b1;
                  w_pend_d  = 1'b1;
               end else begin
                  w_state_d = W_RESP;
                  bresp_d   = 2'b11;
                  w_miss    = 1'b1;
               end
            end
         end
         W_ISSUE: begin
            m_awvalid[w_sel_q] = aw_pend_q;
            m_wvalid[w_sel_q]  = w_pend_q;
            if (aw_pend_q && m_awready[w_sel_q]) aw_pend_d = 1'b0;
            if (w_pend_q && m_wready[w_sel_q])   w_pend_d  = 1'b0;
            if (!aw_pend_d && !w_pend_d) w_state_d = W_WAIT_B;
         end
         W_WAIT_B: begin
            m_bready[w_sel_q] = 1'b1;
            if (m_bvalid[w_sel_q]) begin
               bresp_d   = m_bresp[int'(w_sel_q)*2 +: 2];
               w_state_d = W_RESP;
            end
         end
         default: begin
            s_bvalid = 1'b1;
            if (s_bready) w_state_d = W_IDLE;
         end
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      araddr_d  = araddr_q;
      arprot_d  = arprot_q;
      r_sel_d   = r_sel_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      s_arready = 1'b0;
      s_rvalid  = 1'b0;
      m_arvalid = '0;
      m_rready  = '0;
      r_miss    = 1'b0;
      r_dec     = '0;
      case (r_state_q)
         R_IDLE: begin
            s_arready = 1'b1;
            if (s_arvalid) begin
               r_dec    = decode(s_araddr);
               araddr_d = s_araddr[M_ADDR_WIDTH-1:0];
               arprot_d = s_arprot;
               if (r_dec[SEL_W]) begin
                  r_state_d = R_ISSUE;
                  r_sel_d   = r_dec[SEL_W-1:0];
               end else begin
                  r_state_d = R_RESP;
                  rdata_d   = '0;
                  rresp_d   = 2'b11;
                  r_miss    = 1'b1;
               end
            end
         end
         R_ISSUE: begin
            m_arvalid[r_sel_q] = 1'b1;
            if (m_arready[r_sel_q]) r_state_d = R_WAIT_R;
         end
         R_WAIT_R: begin
            m_rready[r_sel_q] = 1'b1;
            if (m_rvalid[r_sel_q]) begin
               rdata_d   = m_rdata[int'(r_sel_q)*DATA_WIDTH +: DATA_WIDTH];
               rresp_d   = m_rresp[int'(r_sel_q)*2 +: 2];
               r_state_d = R_RESP;
            end
         end
         default: begin
            s_rvalid = 1'b1;
            if (s_rready) r_state_d = R_IDLE;
         end
      endcase
   end

   assign dec_err_d = w_miss || r_miss;

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
         awaddr_q  <= '0;
         awprot_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         w_sel_q   <= '0;
         bresp_q   <= '0;
         r_state_q <= R_IDLE;
         araddr_q  <= '0;
         arprot_q  <= '0;
         r_sel_q   <= '0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         dec_err_q <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         aw_pend_q <= aw_pend_d;
         w_pend_q  <= w_pend_d;
         awaddr_q  <= awaddr_d;
         awprot_q  <= awprot_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         w_sel_q   <= w_sel_d;
         bresp_q   <= bresp_d;
         r_state_q <= r_state_d;
         araddr_q  <= araddr_d;
         arprot_q  <= arprot_d;
         r_sel_q   <= r_sel_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         dec_err_q <= dec_err_d;
      end
   end

   // Payload is broadcast; only the selected port ever sees a valid.
   assign m_awaddr = {N_PORTS{awaddr_q[M_ADDR_WIDTH-1:0]}};
   assign m_awprot = {N_PORTS{awprot_q}};
   assign m_wdata  = {N_PORTS{wdata_q}};
   assign m_wstrb  = {N_PORTS{wstrb_q}};
   assign m_araddr = {N_PORTS{araddr_q}};
   assign m_arprot = {N_PORTS{arprot_q}};
   assign s_bresp  = bresp_q;
   assign s_rdata  = rdata_q;
   assign s_rresp  = rresp_q;
   assign dec_err  = dec_err_q;

endmodule

// File: tb/tb_axil_demux_1xn.sv
// Directed bench for axil_demux_1xn with a 4-port map at 0x0/1/2/3 << 28 and stub slaves.
module tb_axil_demux_1xn;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
   logic [2:0]  s_awprot, s_arprot;
   logic [3:0]  s_wstrb;
   logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic        s_arvalid, s_arready, s_rvalid, s_rready, dec_err;
   logic [1:0]  s_bresp, s_rresp;
   logic [N*24-1:0] m_awaddr, m_araddr;
   logic [N*3-1:0]  m_awprot, m_arprot;
   logic [N*32-1:0] m_wdata, m_rdata;
   logic [N*4-1:0]  m_wstrb;
   logic [N*2-1:0]  m_bresp, m_rresp;
   logic [N-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
   logic            b_en;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Stub slaves: port 3 answers writes with SLVERR, read data identifies the port.
   assign m_bvalid = {N{b_en}};
   assign m_bresp  = {2'b10, 2'b00, 2'b00, 2'b00};
   assign m_rvalid = '1;
   assign m_rresp  = '0;
   assign m_rdata  = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};

   axil_demux_1xn #(
      .N_PORTS(4), .ADDR_WIDTH(32), .M_ADDR_WIDTH(24), .DATA_WIDTH(32), .STRB_WIDTH(4),
      .BASE_ADDR({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
      .ADDR_MASK({4{32'hF000_0000}})
   ) dut (
      .clk(clk), .rst(rst),
      .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .dec_err(dec_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      s_awaddr = '0; s_awprot = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
      s_bready = 0; s_araddr = '0; s_arprot = '0; s_arvalid = 0; s_rready = 0;
      m_awready = '1; m_wready = '1; m_arready = '1; b_en = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();

      // reset state
      chk("rst_ready", {s_awready, s_wready, s_arready}, 3'b111);
      chk("rst_mvalid", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 20'h0);
      chk("rst_svalid", {s_bvalid, s_rvalid, dec_err}, 3'b000);

      // 1: write hit to port 1
      s_awaddr = 32'h1000_0010; s_awprot = 3'b010; s_awvalid = 1;
      s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wvalid = 1; s_bready = 1;
      tick();
      s_awvalid = 0; s_wvalid = 0;
      chk("t1_awvalid", m_awvalid, 4'b0010);
      chk("t1_wvalid", m_wvalid, 4'b0010);
      chk("t1_awaddr", m_awaddr[24 +: 24], 24'h000010);
      chk("t1_awprot", m_awprot[3 +: 3], 3'b010);
      chk("t1_wdata", m_wdata[32 +: 32], 32'hDEAD_BEEF);
      chk("t1_awready_busy", {s_awready, s_wready}, 2'b00);
      tick();
      chk("t1_bready", m_bready, 4'b0010);
      chk("t1_valid_drop", {m_awvalid, m_wvalid}, 8'h00);
      chk("t1_bvalid_c2", s_bvalid, 1'b0);
      tick();
      chk("t1_bvalid_c3", s_bvalid, 1'b1);
      chk("t1_bresp", s_bresp, 2'b00);
      tick();
      chk("t1_done", {s_bvalid, s_awready, s_wready}, 3'b011);

      // 2: read miss
      s_araddr = 32'h4000_0000; s_arvalid = 1; s_rready = 0;
      tick();
      s_arvalid = 0;
      chk("t2_arvalid", m_arvalid, 4'b0000);
      chk("t2_rvalid", s_rvalid, 1'b1);
      chk("t2_rresp", s_rresp, 2'b11);
      chk("t2_rdata", s_rdata, 32'h0);
      chk("t2_dec_err", dec_err, 1'b1);
      s_rready = 1;
      tick();
      chk("t2_dec_err_off", dec_err, 1'b0);
      chk("t2_rvalid_off", {s_rvalid, s_arready}, 2'b01);

      // 3: W three cycles before AW, with a one-cycle W stall downstream
      s_wdata = 32'h1234_5678; s_wstrb = 4'h3; s_wvalid = 1;
      tick();
      s_wvalid = 0;
      chk("t3_wready_held", {s_wready, s_awready}, 2'b01);
      tick();
      tick();
      chk("t3_idle_wait", {m_awvalid, m_wvalid}, 8'h00);
      s_awaddr = 32'h2000_0004; s_awvalid = 1; m_wready = 4'b1011;
      tick();
      s_awvalid = 0;
      chk("t3_awvalid", m_awvalid, 4'b0100);
      chk("t3_wvalid", m_wvalid, 4'b0100);
      chk("t3_awaddr", m_awaddr[48 +: 24], 24'h000004);
      chk("t3_wdata", m_wdata[64 +: 32], 32'h1234_5678);
      chk("t3_wstrb", m_wstrb[8 +: 4], 4'h3);
      tick();
      chk("t3_aw_drop_w_hold", {m_awvalid, m_wvalid}, 8'b0000_0100);
      m_wready = '1;
      tick();
      chk("t3_bready", m_bready, 4'b0100);
      tick();
      chk("t3_bvalid", {s_bvalid, s_bresp}, 3'b100);
      tick();
      chk("t3_done", {s_bvalid, s_awready}, 2'b01);

      // 4: read backpressure downstream then upstream
      s_araddr = 32'h0000_0100; s_arvalid = 1; s_rready = 0; m_arready = 4'b1110;
      tick();
      s_arvalid = 0;
      chk("t4_araddr", m_araddr[0 +: 24], 24'h000100);
      for (int i = 0; i < 4; i++) begin
         chk("t4_arvalid_held", {m_arvalid, s_arready}, 5'b00010);
         if (i < 3) tick();
      end
      m_arready = '1;
      tick();
      chk("t4_rready", {m_rready, m_arvalid}, 8'b0001_0000);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t4_rvalid_stable", {s_rvalid, s_arready, s_rresp}, 4'b1000);
         chk("t4_rdata_stable", s_rdata, 32'hCAFE_0000);
         tick();
      end
      s_rready = 1;
      tick();
      chk("t4_done", {s_rvalid, s_arready}, 2'b01);

      // 5: concurrent read port 0, write port 3
      s_araddr = 32'h0000_0000; s_arvalid = 1;
      s_awaddr = 32'h3000_0008; s_awvalid = 1; s_wdata = 32'hA5A5_5A5A; s_wstrb = 4'hF; s_wvalid = 1;
      tick();
      s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
      chk("t5_issue", {m_arvalid, m_awvalid, m_wvalid}, 12'b0001_1000_1000);
      tick();
      chk("t5_wait", {m_rready, m_bready, m_arvalid, m_awvalid}, 16'b0001_1000_0000_0000);
      chk("t5_c2", {s_rvalid, s_bvalid}, 2'b00);
      tick();
      chk("t5_c3", {s_rvalid, s_bvalid}, 2'b11);
      chk("t5_rdata", {s_rdata, s_rresp}, {32'hCAFE_0000, 2'b00});
      chk("t5_bresp", s_bresp, 2'b10);
      tick();
      chk("t5_done", {s_rvalid, s_bvalid, dec_err}, 3'b000);

      // 6: reset while waiting for B
      b_en = 1'b0;
      s_awaddr = 32'h1000_0020; s_awvalid = 1; s_wdata = 32'h1; s_wvalid = 1;
      tick();
      s_awvalid = 0; s_wvalid = 0;
      tick();
      tick();
      chk("t6_wait_b", m_bready, 4'b0010);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, s_bvalid}, 17'h0);
      chk("t6_rst_ready", {s_awready, s_wready}, 2'b11);
      b_en = 1'b1;
      s_awaddr = 32'h0000_0004; s_awvalid = 1; s_wdata = 32'h5555_AAAA; s_wvalid = 1;
      tick();
      s_awvalid = 0; s_wvalid = 0;
      chk("t6_reissue", {m_awvalid, m_wvalid}, 8'b0001_0001);
      tick();
      tick();
      chk("t6_bvalid", {s_bvalid, s_bresp}, 3'b100);
      tick();

      // 7: simultaneous read and write misses give one dec_err pulse
      s_awaddr = 32'h8000_0000; s_awvalid = 1; s_wvalid = 1;
      s_araddr = 32'hF000_0000; s_arvalid = 1; s_rready = 0; s_bready = 0;
      tick();
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      chk("t7_resp", {s_bvalid, s_bresp, s_rvalid, s_rresp}, 6'b111_111);
      chk("t7_dec_err", dec_err, 1'b1);
      chk("t7_no_mvalid", {m_awvalid, m_wvalid, m_arvalid}, 12'h0);
      tick();
      chk("t7_dec_err_once", {dec_err, s_bvalid, s_rvalid}, 3'b011);
      s_rready = 1; s_bready = 1;
      tick();
      chk("t7_done", {s_bvalid, s_rvalid, s_awready, s_arready}, 4'b0011);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
